// File: rtl/byte_decode_gb.sv
// byte_decode_gb: ByteDecode_l unpacker for the Kyber datapath.
// Turns a stream of IW-bit packed words (LSB-first bit order) into NC coefficients
// of l bits each (l in {1,4,5,10,11,12}), emitted NL lanes per beat as
// zero-extended 16-bit values. Valid/ready handshakes on both sides.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_ibytes/_valid        packed input word and its valid
//   o_ibytes_ready         input word accepted on valid & ready
//   i_l                    coefficient width, sampled on the first word of a polynomial
//   o_coeffs/_valid        NL coefficient lanes and beat valid (held until accepted)
//   i_coeffs_ready         downstream ready
//   o_done                 one-cycle pulse after the final beat is accepted
//   o_err                  illegal i_l offered while idle
//
// Optional feature: define MODQ_REDUCE_EN to reduce 12-bit lanes modulo q=3329
// with a single conditional subtract ahead of the output register.
module byte_decode_gb #(
  parameter int unsigned IW = 64,
  parameter int unsigned NL = 4,
  parameter int unsigned NC = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [IW-1:0]      i_ibytes,
  input  logic               i_ibytes_valid,
  output logic               o_ibytes_ready,
  input  logic [3:0]         i_l,
  output logic [NL*16-1:0]   o_coeffs,
  output logic               o_coeffs_valid,
  input  logic               i_coeffs_ready,
  output logic               o_done,
  output logic               o_err
);

  localparam int unsigned BUFW  = 2 * IW;
  localparam int unsigned FW    = $clog2(BUFW + 1);
  localparam int unsigned WMAX  = (NC * 12) / IW;
  localparam int unsigned WCW   = $clog2(WMAX + 1);
  localparam int unsigned NBEAT = NC / NL;
  localparam int unsigned BCW   = $clog2(NBEAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BUFW-1:0]     buf_q, buf_d, buf_sh;
  logic [FW-1:0]       fill_q, fill_d, fill_sh, beat_bits;
  logic [WCW-1:0]      wcnt_q, wcnt_d, words_total;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [3:0]          l_q, l_d;
  logic [NL*16-1:0]    coeffs_q, lanes_c;
  logic                cvalid_q, cvalid_d;
  logic                done_q, done_d;
  logic                l_legal, ready_c, acc, out_acc, emit;
  logic [15:0]         mask, lane;

  // Words per polynomial for each legal width; constants avoid a divider.
  function automatic logic [WCW-1:0] words_for(input logic [3:0] l);
    case (l)
      4'd1:    words_for = WCW'((NC * 1) / IW);
      4'd4:    words_for = WCW'((NC * 4) / IW);
      4'd5:    words_for = WCW'((NC * 5) / IW);
      4'd10:   words_for = WCW'((NC * 10) / IW);
      4'd11:   words_for = WCW'((NC * 11) / IW);
      4'd12:   words_for = WCW'((NC * 12) / IW);
      default: words_for = '0;
    endcase
  endfunction

  // Handshake qualification and bit-buffer datapath.
  always_comb begin
    l_legal     = (i_l == 4'd1) || (i_l == 4'd4) || (i_l == 4'd5) ||
                  (i_l == 4'd10) || (i_l == 4'd11) || (i_l == 4'd12);
    words_total = words_for(l_q);
    beat_bits   = FW'(NL) * FW'(l_q);

    ready_c = 1'b0;
    case (state_q)
      S_IDLE:  ready_c = l_legal;
      S_RUN:   ready_c = (wcnt_q < words_total) && (fill_q <= FW'(BUFW - IW));
      default: ready_c = 1'b0;
    endcase
    if (i_rst) ready_c = 1'b0;

    acc     = i_ibytes_valid && ready_c;
    out_acc = cvalid_q && i_coeffs_ready;
    emit    = (state_q == S_RUN) && (fill_q >= beat_bits) && (!cvalid_q || i_coeffs_ready);

    // Drop the emitted beat first, then append the new word above what remains.
    buf_sh  = emit ? (buf_q >> beat_bits) : buf_q;
    fill_sh = emit ? (fill_q - beat_bits) : fill_q;
    buf_d   = acc ? (buf_sh | (BUFW'(i_ibytes) << fill_sh)) : buf_sh;
    fill_d  = acc ? (fill_sh + FW'(IW)) : fill_sh;
  end

  // Lane extraction from the bottom of the buffer.
  always_comb begin
    lanes_c = '0;
    lane    = '0;
    mask    = (16'd1 << l_q) - 16'd1;
    for (int j = 0; j < NL; j++) begin
      lane = 16'(buf_q >> (FW'(j) * FW'(l_q))) & mask;
`ifdef MODQ_REDUCE_EN
      // 4095 < 2q, so one conditional subtract fully reduces a 12-bit value.
      if ((l_q == 4'd12) && (lane >= 16'd3329)) lane = lane - 16'd3329;
`endif
      lanes_c[16*j +: 16] = lane;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    l_d      = l_q;
    cvalid_d = cvalid_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_RUN;
          l_d     = i_l;
          wcnt_d  = WCW'(1);
        end
      end
      S_RUN: begin
        if (acc) wcnt_d = wcnt_q + WCW'(1);
        if (emit) cvalid_d = 1'b1;
        else if (out_acc) cvalid_d = 1'b0;
        if (out_acc) begin
          if (bcnt_q == BCW'(NBEAT - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        wcnt_d   = '0;
        bcnt_d   = '0;
        cvalid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      fill_q   <= '0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      l_q      <= '0;
      coeffs_q <= '0;
      cvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= (state_q == S_DONE) ? '0 : buf_d;
      fill_q   <= (state_q == S_DONE) ? '0 : fill_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      l_q      <= l_d;
      cvalid_q <= cvalid_d;
      done_q   <= done_d;
      if (emit) coeffs_q <= lanes_c;
    end
  end

  assign o_ibytes_ready = ready_c;
  assign o_coeffs       = coeffs_q;
  assign o_coeffs_valid = cvalid_q;
  assign o_done         = done_q;
  assign o_err          = !i_rst && (state_q == S_IDLE) && i_ibytes_valid && !l_legal;

endmodule

// File: tb/tb_byte_decode_gb.sv
`timescale 1ns/1ps
module tb_byte_decode_gb;
  localparam int unsigned IW = 64;
  localparam int unsigned NL = 4;
  localparam int unsigned NC = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [IW-1:0]     ibytes;
  logic              ivalid;
  logic              ordy;
  logic [3:0]        l_in;
  logic [NL*16-1:0]  coeffs;
  logic              cvalid;
  logic              cready;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  int got_q[$];
  int words_acc, beats_acc, stab_viol, rdy_viol;
  bit done_seen;

  always #5 clk = ~clk;

  byte_decode_gb #(.IW(IW), .NL(NL), .NC(NC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibytes(ibytes), .i_ibytes_valid(ivalid), .o_ibytes_ready(ordy),
    .i_l(l_in),
    .o_coeffs(coeffs), .o_coeffs_valid(cvalid), .i_coeffs_ready(cready),
    .o_done(done), .o_err(err)
  );

  // Stream byte k for each stimulus pattern.
  function automatic logic [7:0] byte_of(input int pat, input int k);
    case (pat)
      0:       return 8'hFF;
      1:       return 8'(1 + 34 * k);
      default: return 8'(37 * k + 5);
    endcase
  endfunction

  function automatic logic [IW-1:0] word_of(input int pat, input int idx);
    logic [IW-1:0] w;
    w = '0;
    for (int b = 0; b < IW / 8; b++) w[8*b +: 8] = byte_of(pat, idx * (IW / 8) + b);
    return w;
  endfunction

  // Reference coefficient n read bit by bit from the byte stream.
  function automatic int exp_coeff(input int pat, input int l, input int n);
    int v, s;
    logic [7:0] by;
    v = 0;
    for (int b = 0; b < l; b++) begin
      s  = n * l + b;
      by = byte_of(pat, s / 8);
      if (by[s % 8]) v = v | (1 << b);
    end
`ifdef MODQ_REDUCE_EN
    if (l == 12 && v >= 3329) v = v - 3329;
`endif
    return v;
  endfunction

  // Drives one polynomial; records accepted lanes and protocol violations.
  // stop_words > 0 abandons the run after that many words are handed over.
  task automatic run_poly(input int l, input int pat, input int rmode, input int stop_words);
    int total, fillm;
    bit prev_v, prev_r, exp_rdy;
    logic [NL*16-1:0] prev_c;
    total = (NC * l) / IW;
    got_q.delete();
    words_acc = 0; beats_acc = 0; stab_viol = 0; rdy_viol = 0; done_seen = 0;
    prev_v = 0; prev_r = 0; prev_c = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen = 1;
        ivalid = 1'b0;
        break;
      end
      if (prev_v && !prev_r && (cvalid !== 1'b1 || coeffs !== prev_c)) stab_viol++;
      fillm = words_acc * IW - (beats_acc + int'(cvalid)) * NL * l;
      l_in   = (rmode == 1 && words_acc > 0) ? 4'd5 : 4'(l);
      ibytes = word_of(pat, words_acc);
      ivalid = 1'b1;
      cready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (words_acc > 0) begin
        exp_rdy = (words_acc < total) && (fillm <= IW);
        if (ordy !== exp_rdy) rdy_viol++;
      end
      if (cvalid && cready) begin
        for (int j = 0; j < NL; j++) got_q.push_back(int'(coeffs[16*j +: 16]));
        beats_acc++;
      end
      if (ivalid && ordy) words_acc++;
      prev_v = cvalid; prev_r = cready; prev_c = coeffs;
      if (stop_words > 0 && words_acc == stop_words) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ivalid = 1'b1; l_in = 4'd4; ibytes = word_of(0, 0); cready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ordy !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ordy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL rst_cvalid got %b want 0", cvalid); end
    checks++; if (coeffs !== '0) begin errors++; $display("FAIL rst_coeffs got %h want 0", coeffs); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    rst = 1'b0; ivalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_l1();
    run_poly(1, 0, 0, 0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL l1_done got %b want 1", done_seen); end
    checks++; if (words_acc !== 4) begin errors++; $display("FAIL l1_words got %0d want 4", words_acc); end
    checks++; if (got_q.size() !== NC) begin errors++; $display("FAIL l1_count got %0d want %0d", got_q.size(), NC); end
    for (int n = 0; n < NC; n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== 1) begin
        errors++; $display("FAIL l1_coeff[%0d] got %0h want 1", n, (n < got_q.size()) ? got_q[n] : -1);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL l1_done_pulse got %b want 0", done); end
    checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL l1_idle_cvalid got %b want 0", cvalid); end
  endtask

  task automatic test_l12_seq();
    int want[4];
    want[0] = 'h301; want[1] = 'h452; want[2] = 'h967; want[3] = 'hAB8;
    run_poly(12, 1, 0, 0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL l12_done got %b want 1", done_seen); end
    checks++; if (words_acc !== 48) begin errors++; $display("FAIL l12_words got %0d want 48", words_acc); end
    checks++; if (got_q.size() !== NC) begin errors++; $display("FAIL l12_count got %0d want %0d", got_q.size(), NC); end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL l12_ready got %0d bad cycles want 0", rdy_viol); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= got_q.size() || got_q[j] !== want[j]) begin
        errors++; $display("FAIL l12_beat0_lane%0d got %0h want %0h", j, (j < got_q.size()) ? got_q[j] : -1, want[j]);
      end
    end
    for (int n = 0; n < NC; n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== exp_coeff(1, 12, n)) begin
        errors++; $display("FAIL l12_coeff[%0d] got %0h want %0h", n, (n < got_q.size()) ? got_q[n] : -1, exp_coeff(1, 12, n));
      end
    end
  endtask

  task automatic test_backpressure();
    run_poly(12, 2, 1, 0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done_seen); end
    checks++; if (words_acc !== 48) begin errors++; $display("FAIL bp_words got %0d want 48", words_acc); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles want 0", stab_viol); end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL bp_ready got %0d bad cycles want 0", rdy_viol); end
    checks++; if (got_q.size() !== NC) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), NC); end
    for (int n = 0; n < NC; n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== exp_coeff(2, 12, n)) begin
        errors++; $display("FAIL bp_coeff[%0d] got %0h want %0h", n, (n < got_q.size()) ? got_q[n] : -1, exp_coeff(2, 12, n));
      end
    end
  endtask

  task automatic test_modq();
    int want;
`ifdef MODQ_REDUCE_EN
    want = 'h2FE;
`else
    want = 'hFFF;
`endif
    run_poly(12, 0, 0, 0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL modq_done got %b want 1", done_seen); end
    checks++; if (got_q.size() !== NC) begin errors++; $display("FAIL modq_count got %0d want %0d", got_q.size(), NC); end
    for (int n = 0; n < NC; n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== want) begin
        errors++; $display("FAIL modq_coeff[%0d] got %0h want %0h", n, (n < got_q.size()) ? got_q[n] : -1, want);
      end
    end
  endtask

  task automatic test_illegal_l();
    ivalid = 1'b1; l_in = 4'd3; ibytes = word_of(1, 0); cready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++; if (ordy !== 1'b0) begin errors++; $display("FAIL ill_ready got %b want 0", ordy); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", err); end
    end
    l_in = 4'd4; #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_clear got %b want 0", err); end
    checks++; if (ordy !== 1'b1) begin errors++; $display("FAIL ill_ready_legal got %b want 1", ordy); end
    ivalid = 1'b0;
    run_poly(4, 1, 0, 0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL l4_done got %b want 1", done_seen); end
    checks++; if (words_acc !== 16) begin errors++; $display("FAIL l4_words got %0d want 16", words_acc); end
    checks++; if (got_q.size() !== NC) begin errors++; $display("FAIL l4_count got %0d want %0d", got_q.size(), NC); end
    for (int n = 0; n < NC; n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== exp_coeff(1, 4, n)) begin
        errors++; $display("FAIL l4_coeff[%0d] got %0h want %0h", n, (n < got_q.size()) ? got_q[n] : -1, exp_coeff(1, 4, n));
      end
    end
  endtask

  task automatic test_reset_mid();
    run_poly(10, 2, 0, 7);
    checks++; if (words_acc !== 7) begin errors++; $display("FAIL mid_words got %0d want 7", words_acc); end
    @(negedge clk);
    ivalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL mid_cvalid got %b want 0", cvalid); end
    checks++; if (coeffs !== '0) begin errors++; $display("FAIL mid_coeffs got %h want 0", coeffs); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    checks++; if (ordy !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", ordy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", err); end
    rst = 1'b0; l_in = 4'd10; #1;
    checks++; if (ordy !== 1'b1) begin errors++; $display("FAIL mid_idle_ready got %b want 1", ordy); end
    run_poly(10, 1, 0, 0);
    checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL l10_done got %b want 1", done_seen); end
    checks++; if (words_acc !== 40) begin errors++; $display("FAIL l10_words got %0d want 40", words_acc); end
    checks++; if (got_q.size() !== NC) begin errors++; $display("FAIL l10_count got %0d want %0d", got_q.size(), NC); end
    for (int n = 0; n < NC; n++) begin
      checks++;
      if (n >= got_q.size() || got_q[n] !== exp_coeff(1, 10, n)) begin
        errors++; $display("FAIL l10_coeff[%0d] got %0h want %0h", n, (n < got_q.size()) ? got_q[n] : -1, exp_coeff(1, 10, n));
      end
    end
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; ibytes = '0; l_in = 4'd0; cready = 1'b0;
    test_reset();
    test_l1();
    test_l12_seq();
    test_backpressure();
    test_modq();
    test_illegal_l();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_decode_gb.md
Name: byte_decode_gb

Overview:
- Parametrised ByteDecode_l unpacker for the Kyber datapath. It converts a stream of IW-bit packed words into one polynomial of NC coefficients, each l bits wide, with l in {1,4,5,10,11,12}.
- It emits NL zero-extended 16-bit coefficient lanes per output beat, with full valid/ready backpressure on both sides.
- It sits between the byte-stream input buffer and polynomial RAM/NTT.

Parameters:
IW, 64, input word width in bits; multiple of 8; NC*l must be divisible by IW for every legal l
NL, 4, coefficient lanes per output beat; must be one of 1, 2, 4
NC, 256, coefficients per polynomial; NC divisible by NL

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  synchronous, active-high reset
i_ibytes  in  IW  packed input word; byte k = i_ibytes[8k+7:8k]; byte 0 is first in the stream
i_ibytes_valid  in  1  input word valid
o_ibytes_ready  out  1  input word accepted when valid & ready
i_l  in  4  coefficient bit width; sampled on the first input handshake of a polynomial
o_coeffs  out  NL*16  lane j = o_coeffs[16j+15:16j] is coefficient (beat*NL + j), zero-extended
o_coeffs_valid  out  1  output beat valid; held with stable data until accepted
i_coeffs_ready  in  1  downstream ready
o_done  out  1  one-cycle pulse after the final beat of a polynomial is accepted
o_err  out  1  high while in S_IDLE with i_ibytes_valid=1 and i_l illegal

Behaviour:
- Reset (i_rst=1 at an edge), including mid-operation:
  - state goes to S_IDLE; bit buffer, fill count, word count and beat count clear to 0.
  - o_coeffs=0, o_coeffs_valid=0, o_done=0. o_err=0 and o_ibytes_ready=0 while reset is asserted.
  - Any partial polynomial is discarded.
- Bit order: the stream is read LSB-first. Bit b of byte k is stream bit 8k+b. Coefficient n = stream bits [n*l + l-1 : n*l], with stream bit n*l as its LSB.
- Bit buffer:
  - Width BUFW = 2*IW bits; fill counter 0..BUFW.
  - An accepted word is appended above the current fill.
  - An emitted beat removes NL*l bits from the bottom; the remaining bits shift down.
  - Accept and emit may occur in the same cycle: fill_next = fill + IW*acc - NL*l*emit.
- State machine:
  - S_IDLE:
    - o_ibytes_ready = 1 iff i_l is legal.
    - On handshake: latch l_r = i_l, load the word (fill=IW), word count = 1, go to S_RUN.
    - Illegal i_l: no handshake; stay in S_IDLE; o_err follows the definition in Ports.
  - S_RUN:
    - o_ibytes_ready = (word count < NC*l_r/IW) & (registered fill <= BUFW-IW).
    - Emission occurs when (fill >= NL*l_r) & (!o_coeffs_valid | i_coeffs_ready); it loads the o_coeffs register from the buffer.
    - o_coeffs_valid is set on emission and cleared on acceptance without a new emission.
    - When the beat number NC/NL is accepted, go to S_DONE.
    - i_l changes during S_RUN are ignored.
  - S_DONE:
    - o_done=1 and o_ibytes_ready=0 for exactly one cycle; counters clear; next state S_IDLE.
- Latency:
  - A word accepted at edge k can produce o_coeffs_valid after edge k+1, provided fill >= NL*l.
  - Sustained throughput is one beat per cycle whenever input bits suffice.
- No deadlock: when fill > BUFW-IW, fill >= NL*12, so emission is always possible once downstream is ready.
- Exactly NC*l/IW words are consumed per polynomial; extra words remain unaccepted until the next S_IDLE.
- Fill is exactly 0 at S_DONE (guaranteed by the divisibility rule).
- o_coeffs_valid=1 with i_coeffs_ready=0 holds o_coeffs stable indefinitely.

Optional Feature:
- Macro MODQ_REDUCE_EN.
- Defined: when l_r=12, each lane value v >= 3329 is output as v-3329, using a single conditional subtract (4095 < 2q). Other values of l are unaffected. The subtract is combinational before the o_coeffs register, so latency is unchanged.
- Undefined: raw l-bit values are output for all l.

Test Plan:
1. l=1, 4 words of 0xFFFF_FFFF_FFFF_FFFF, i_coeffs_ready=1 -> 64 beats of lanes all 0x0001 (NL=4), then o_done pulse; 4 words accepted, 5th word not accepted.
2. l=12, stream bytes 01 23 45 67 89 AB ... -> beat 0 lanes 0x0301, 0x0452, 0x0967, 0x0AB8; total 48 words, 64 beats.
3. l=12, toggle i_coeffs_ready pseudo-randomly -> o_coeffs stable while valid & !ready, no lost or duplicated coefficients, o_ibytes_ready drops whenever fill > 64.
4. l=12, all-ones input -> with MODQ_REDUCE_EN every lane is 766 (0x02FE); without it, 0x0FFF.
5. i_l=3 with i_ibytes_valid=1 -> o_ibytes_ready=0 and o_err=1; switch to i_l=4 -> handshake occurs, o_err=0, polynomial completes after 16 words.
6. l=10, assert i_rst for 1 cycle after 7 words -> all outputs 0 the next cycle, state S_IDLE; a fresh polynomial then decodes correctly.
